// File: rtl/buffer_occupancy_counter_pkg.sv
// Shared helpers for the pipeline-stage slot counters.
// Arithmetic is done at a fixed 32-bit width so callers of any count width can share it.
package proc_counters_pkg;

  typedef logic [31:0] count_t;

  localparam int ERR_OVERRUN        = 0;
  localparam int ERR_KILL_UNDERFLOW = 1;

  function automatic count_t min_count(input count_t a, input count_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic count_t sat_sub(input count_t a, input count_t b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/buffer_occupancy_counter_arith.sv
// Combinational handshake arithmetic for one buffer stage: survivors after kill,
// the downstream offer and transfer, and the upstream transfer.
module buffer_count_arith
  import proc_counters_pkg::*;
#(
  parameter int W              = 8,
  parameter int MAX_OUT        = 4,
  parameter int ALL_OR_NOTHING = 0
) (
  input  logic [W-1:0] full,
  input  logic [W-1:0] kill,
  input  logic         killAll,
  input  logic         lockSend,
  input  logic [W-1:0] nextAccepting,
  input  logic [W-1:0] prevSending,
  input  logic [W-1:0] canAccept,
  output logic [W-1:0] living,
  output logic [W-1:0] wantSend,
  output logic [W-1:0] sending,
  output logic [W-1:0] afterSending,
  output logic [W-1:0] accepting,
  output logic         killUnderflow,
  output logic         overrun
);

  // Kill removes the youngest entries first; sends come only from the survivors.
  assign living   = killAll ? '0 : W'(sat_sub(32'(full), 32'(kill)));
  assign wantSend = lockSend ? '0 : W'(min_count(32'(MAX_OUT), 32'(living)));

  assign sending = (ALL_OR_NOTHING != 0)
                   ? ((nextAccepting >= wantSend) ? wantSend : '0)
                   : W'(min_count(32'(nextAccepting), 32'(wantSend)));

  assign afterSending = living - sending;

  // Entries offered beyond canAccept are dropped and flagged, never counted.
  assign accepting = killAll ? '0 : W'(min_count(32'(prevSending), 32'(canAccept)));

  assign killUnderflow = !killAll && (kill > full);
  assign overrun       = !killAll && (prevSending > canAccept);

endmodule

// File: rtl/buffer_occupancy_counter.sv
// Registered occupancy counter for one pipeline buffer stage, with sticky
// protocol-error flags and a conservative upstream offer based on stored occupancy.
module buffer_occupancy_counter
  import proc_counters_pkg::*;
#(
  parameter int W              = 8,
  parameter int CAPACITY       = 16,
  parameter int MAX_IN         = 4,
  parameter int MAX_OUT        = 4,
  parameter int ALL_OR_NOTHING = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         lock_accept,
  input  logic         lock_send,
  input  logic         kill_all,
  input  logic [W-1:0] kill,
  input  logic [W-1:0] next_accepting,
  input  logic [W-1:0] prev_sending,
  output logic [W-1:0] full,
  output logic [W-1:0] living,
  output logic [W-1:0] want_send,
  output logic [W-1:0] can_accept,
  output logic [W-1:0] sending,
  output logic [W-1:0] accepting,
  output logic [W-1:0] after_sending,
  output logic         is_empty,
  output logic         is_full,
  output logic [1:0]   err
);

  localparam logic [W-1:0] CAP = W'(CAPACITY);

  if (CAPACITY >= 2**W || MAX_IN > CAPACITY || MAX_OUT > CAPACITY) begin : gBadParams
    $error("buffer_occupancy_counter: illegal parameter combination");
  end

  logic [W-1:0] fullQ;
  logic [1:0]   errQ;
  logic         killUnderflow;
  logic         overrun;

  // Only the stored occupancy feeds the upstream offer, so next_accepting never
  // reaches the previous stage combinationally.
  assign can_accept = lock_accept ? '0
                      : W'(min_count(32'(MAX_IN), sat_sub(32'(CAP), 32'(fullQ))));

  buffer_count_arith #(
    .W             (W),
    .MAX_OUT       (MAX_OUT),
    .ALL_OR_NOTHING(ALL_OR_NOTHING)
  ) arith (
    .full         (fullQ),
    .kill         (kill),
    .killAll      (kill_all),
    .lockSend     (lock_send),
    .nextAccepting(next_accepting),
    .prevSending  (prev_sending),
    .canAccept    (can_accept),
    .living       (living),
    .wantSend     (want_send),
    .sending      (sending),
    .afterSending (after_sending),
    .accepting    (accepting),
    .killUnderflow(killUnderflow),
    .overrun      (overrun)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fullQ <= '0;
      errQ  <= '0;
    end else begin
      fullQ                    <= after_sending + accepting;
      errQ[ERR_OVERRUN]        <= errQ[ERR_OVERRUN] | overrun;
      errQ[ERR_KILL_UNDERFLOW] <= errQ[ERR_KILL_UNDERFLOW] | killUnderflow;
    end
  end

  assign full     = fullQ;
  assign err      = errQ;
  assign is_empty = (fullQ == '0);
  assign is_full  = (fullQ == CAP);

  occupancyBound: assert property (@(posedge clk) disable iff (!reset_n)
    ({1'b0, after_sending} + {1'b0, accepting}) <= {1'b0, CAP});

endmodule

// File: tb/tb_buffer_occupancy_counter.sv
// Scoreboard bench: two counters (split and all-or-nothing send) driven in parallel
// and compared every cycle against an integer model of the slot-count rules.
module tb_buffer_occupancy_counter;

  localparam int W       = 8;
  localparam int CAP     = 16;
  localparam int MAX_IN  = 4;
  localparam int MAX_OUT = 4;

  typedef struct {
    int full; int living; int want; int canAcc; int sending;
    int accepting; int after; int isEmpty; int isFull; int err;
  } exp_t;

  logic         clk;
  logic         reset_n;
  logic         lockAccept, lockSend, killAll;
  logic [W-1:0] kill, nextAccepting, prevSending;

  logic [W-1:0] fullO [2];
  logic [W-1:0] livingO [2];
  logic [W-1:0] wantO [2];
  logic [W-1:0] canAccO [2];
  logic [W-1:0] sendingO [2];
  logic [W-1:0] acceptingO [2];
  logic [W-1:0] afterO [2];
  logic         emptyO [2];
  logic         isFullO [2];
  logic [1:0]   errO [2];

  for (genvar i = 0; i < 2; i++) begin : duts
    buffer_occupancy_counter #(
      .W(W), .CAPACITY(CAP), .MAX_IN(MAX_IN), .MAX_OUT(MAX_OUT), .ALL_OR_NOTHING(i)
    ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .lock_accept   (lockAccept),
      .lock_send     (lockSend),
      .kill_all      (killAll),
      .kill          (kill),
      .next_accepting(nextAccepting),
      .prev_sending  (prevSending),
      .full          (fullO[i]),
      .living        (livingO[i]),
      .want_send     (wantO[i]),
      .can_accept    (canAccO[i]),
      .sending       (sendingO[i]),
      .accepting     (acceptingO[i]),
      .after_sending (afterO[i]),
      .is_empty      (emptyO[i]),
      .is_full       (isFullO[i]),
      .err           (errO[i])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t expQ0[$];
  exp_t expQ1[$];
  int   mFull [2];
  int   mErr [2];

  function automatic int minI(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic cmp(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d at %0t: got %0d expected %0d", name, d, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input int d, input exp_t e);
    cmp("full", d, fullO[d], e.full);
    cmp("living", d, livingO[d], e.living);
    cmp("want_send", d, wantO[d], e.want);
    cmp("can_accept", d, canAccO[d], e.canAcc);
    cmp("sending", d, sendingO[d], e.sending);
    cmp("accepting", d, acceptingO[d], e.accepting);
    cmp("after_sending", d, afterO[d], e.after);
    cmp("is_empty", d, emptyO[d], e.isEmpty);
    cmp("is_full", d, isFullO[d], e.isFull);
    cmp("err", d, errO[d], e.err);
  endtask

  // Drive one cycle of handshake inputs and queue what each counter should show.
  task automatic applyStimulus(input bit la, input bit ls, input bit ka,
                               input int k, input int na, input int ps);
    @(posedge clk);
    #1;
    lockAccept    = la;
    lockSend      = ls;
    killAll       = ka;
    kill          = W'(k);
    nextAccepting = W'(na);
    prevSending   = W'(ps);
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      int f, live, want, snd, canAcc, acc, newErr;
      f      = mFull[d];
      live   = ka ? 0 : ((k > f) ? 0 : f - k);
      want   = ls ? 0 : minI(MAX_OUT, live);
      snd    = (d == 1) ? ((na >= want) ? want : 0) : minI(na, want);
      canAcc = la ? 0 : minI(MAX_IN, CAP - f);
      acc    = ka ? 0 : minI(ps, canAcc);
      newErr = mErr[d];
      if (!ka && ps > canAcc) newErr = newErr | 1;
      if (!ka && k > f)       newErr = newErr | 2;
      e = '{f, live, want, canAcc, snd, acc, live - snd,
            (f == 0) ? 1 : 0, (f == CAP) ? 1 : 0, mErr[d]};
      if (d == 0) expQ0.push_back(e);
      else        expQ1.push_back(e);
      mFull[d] = live - snd + acc;
      mErr[d]  = newErr;
    end
  endtask

  // Pull reset between edges while the counters hold entries; state must clear at once.
  task automatic resetMidCycle();
    @(posedge clk);
    #1;
    lockAccept = 0; lockSend = 0; killAll = 0;
    kill = '0; nextAccepting = '0; prevSending = '0;
    #2;
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      cmp("async_reset_full", d, fullO[d], 0);
      cmp("async_reset_err", d, errO[d], 0);
      mFull[d] = 0;
      mErr[d]  = 0;
    end
    expQ0.delete();
    expQ1.delete();
    @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: every cycle the counters present a fresh set of outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ0.size() > 0) begin e = expQ0.pop_front(); checkOutput(0, e); end
      if (expQ1.size() > 0) begin e = expQ1.pop_front(); checkOutput(1, e); end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t rstExp;
    reset_n = 1'b0;
    lockAccept = 0; lockSend = 0; killAll = 0;
    kill = '0; nextAccepting = '0; prevSending = '0;
    mFull = '{0, 0};
    mErr  = '{0, 0};
    repeat (2) @(negedge clk);
    rstExp = '{0, 0, 0, minI(MAX_IN, CAP), 0, 0, 0, 1, 0, 0};
    checkOutput(0, rstExp);
    checkOutput(1, rstExp);
    #1;
    reset_n = 1'b1;

    // Fill to capacity, then observe the full stage with no offer.
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 4);
    applyStimulus(0, 0, 0, 0, 0, 0);
    // Drain partially, then a mixed send/accept cycle.
    applyStimulus(0, 0, 0, 0, 4, 0);
    applyStimulus(0, 0, 0, 0, 2, 0);
    applyStimulus(0, 0, 0, 0, 2, 3);
    // Downstream short by one, then exactly enough.
    applyStimulus(0, 0, 0, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 4, 0);
    // Kill before send, then kill beyond occupancy.
    applyStimulus(0, 0, 0, 3, 4, 0);
    applyStimulus(0, 0, 0, 0, 0, 4);
    applyStimulus(0, 0, 0, 0, 0, 3);
    applyStimulus(0, 0, 0, 9, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    // Both locks, then a flush with incoming entries.
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 4);
    applyStimulus(1, 1, 0, 0, 4, 4);
    applyStimulus(0, 0, 1, 2, 4, 4);
    applyStimulus(0, 0, 0, 0, 0, 0);
    // Push toward capacity with an oversized offer, then reset mid-operation.
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 4);
    resetMidCycle();
    applyStimulus(0, 0, 0, 0, 2, 3);

    for (int n = 0; n < 400; n++) begin
      int k;
      k = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 10) : 0;
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 29) == 0, k,
                    $urandom_range(0, 5), $urandom_range(0, 5));
      if (n % 100 == 99) resetMidCycle();
    end

    @(negedge clk);
    #1;
    checks++;
    if (expQ0.size() != 0 || expQ1.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ0.size() + expQ1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
